// File: rtl/ram_loader_pkg.sv
// Shared types and helpers for the RAM image loader: FSM state encoding, read
// latency of RAM port A, and the rotate-xor checksum fold.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    VERIFY,
    DRAIN,
    DONE,
    ERROR
  } loader_state_t;

  // Cycles between presenting a_addr and a_data_out being valid.
  localparam int unsigned RD_LATENCY = 1;

  function automatic logic [31:0] chk_fold(input logic [31:0] chk, input logic [31:0] word);
    return {chk[30:0], chk[31]} ^ word;
  endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Stream input and RAM port-A bus of the loader. The loader is the master: it
// drives s_ready and the port-A request, and consumes s_valid/s_data/a_data_out.
interface ram_loader_if #(
  parameter int unsigned ADDR_WIDTH = 16
);

  logic                  s_valid;
  logic                  s_ready;
  logic [31:0]           s_data;
  logic                  a_wr_en;
  logic [3:0]            a_wr_strobe;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0]           a_data_in;
  logic [31:0]           a_data_out;

  modport master (
    input  s_valid,
    input  s_data,
    input  a_data_out,
    output s_ready,
    output a_wr_en,
    output a_wr_strobe,
    output a_addr,
    output a_data_in
  );

  modport slave (
    output s_valid,
    output s_data,
    output a_data_out,
    input  s_ready,
    input  a_wr_en,
    input  a_wr_strobe,
    input  a_addr,
    input  a_data_in
  );

endinterface

// File: rtl/loader_checksum.sv
// Running checksum accumulator with synchronous clear and fold enable; one
// instance tracks written words, another tracks words read back.
module loader_checksum
  import ram_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] word_i,
  output logic [31:0] sum_o
);

  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = chk_fold(sum_q, word_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/ram_loader.sv
// Loads a word stream into RAM port A from base_addr, reads the region back,
// and releases the core from reset only when the read-back checksum matches.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  ram_loader_if.master          bus,
  output logic                  core_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  loader_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

  logic        chk_clr;
  logic        wr_fire;
  logic        rd_issue;
  logic        rd_vld;
  logic        last_word;
  logic [31:0] chk_w;
  logic [31:0] chk_r;
  logic [31:0] chk_r_final;

  assign last_word   = (cnt_q == count_q - ADDR_WIDTH'(1));
  assign rd_vld      = rd_pipe_q[RD_LATENCY-1];
  // DRAIN compares against the fold of the last read, which lands in chk_r only at cycle end.
  assign chk_r_final = chk_fold(chk_r, bus.a_data_out);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    count_d     = count_q;
    chk_clr     = 1'b0;
    wr_fire     = 1'b0;
    rd_issue    = 1'b0;
    bus.s_ready = 1'b0;
    bus.a_addr  = '0;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          base_d  = base_addr;
          count_d = word_count;
          ptr_d   = base_addr;
          cnt_d   = '0;
          chk_clr = 1'b1;
          state_d = (word_count == '0) ? DONE : WRITE;
        end
      end

      WRITE: begin
        bus.s_ready = 1'b1;
        bus.a_addr  = ptr_q;
        if (bus.s_valid) begin
          wr_fire = 1'b1;
          if (last_word) begin
            ptr_d   = base_q;
            cnt_d   = '0;
            state_d = VERIFY;
          end else begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end

      VERIFY: begin
        bus.a_addr = ptr_q;
        rd_issue   = 1'b1;
        ptr_d      = ptr_q + ADDR_WIDTH'(1);
        cnt_d      = cnt_q + ADDR_WIDTH'(1);
        if (last_word) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        state_d = (chk_r_final == chk_w) ? DONE : ERROR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = rd_issue;
  end

  always_comb begin
    bus.a_wr_en     = wr_fire;
    bus.a_wr_strobe = wr_fire ? 4'hF : 4'h0;
    bus.a_data_in   = wr_fire ? bus.s_data : 32'h0;
    busy            = (state_q == WRITE) || (state_q == VERIFY) || (state_q == DRAIN);
    done            = (state_q == DONE);
    error           = (state_q == ERROR);
    core_reset_n    = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      count_q   <= '0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      count_q   <= count_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  loader_checksum u_chk_wr (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (chk_clr),
    .en_i   (wr_fire),
    .word_i (bus.s_data),
    .sum_o  (chk_w)
  );

  loader_checksum u_chk_rd (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (chk_clr),
    .en_i   (rd_vld),
    .word_i (bus.a_data_out),
    .sum_o  (chk_r)
  );

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader against a behavioural port-A RAM with an
// optional single-bit read fault.
module tb_ram_loader;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_count;
  logic          core_reset_n;
  logic          busy;
  logic          done;
  logic          error;

  ram_loader_if #(.ADDR_WIDTH(AW)) bus ();

  ram_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .bus          (bus),
    .core_reset_n (core_reset_n),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Port-A RAM: registered read, byte-strobed write, optional bit0 flip on one address.
  logic [31:0]   mem [0:65535];
  logic [31:0]   rd_q;
  logic [AW-1:0] rd_addr_q;
  logic          fault_en;
  logic [AW-1:0] fault_addr;

  always @(posedge clk) begin
    if (bus.a_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.a_wr_strobe[b]) mem[bus.a_addr][8*b +: 8] <= bus.a_data_in[8*b +: 8];
      end
    end
    rd_q      <= mem[bus.a_addr];
    rd_addr_q <= bus.a_addr;
  end

  assign bus.a_data_out = rd_q ^ {31'b0, fault_en && (rd_addr_q == fault_addr)};

  // Bus monitor, sampled mid-cycle when inputs and outputs are both stable.
  logic [AW-1:0] wr_addr_log [$];
  logic [31:0]   wr_data_log [$];
  int            n_acc = 0;
  int            n_bad_wr = 0;
  int            n_bad_strobe = 0;

  always @(negedge clk) begin
    if (bus.a_wr_en) begin
      wr_addr_log.push_back(bus.a_addr);
      wr_data_log.push_back(bus.a_data_in);
      if (!bus.s_valid) n_bad_wr++;
      if (bus.a_wr_strobe != 4'hF) n_bad_strobe++;
    end else if (bus.a_wr_strobe != 4'h0) begin
      n_bad_strobe++;
    end
    if (bus.s_valid && bus.s_ready) n_acc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] w [$], input bit gap);
    logic hs;
    int   guard;
    for (int i = 0; i < w.size(); i++) begin
      if (gap) begin
        bus.s_valid = 1'b0;
        step();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = w[i];
      guard = 0;
      do begin
        hs = bus.s_ready;
        step();
        guard++;
      end while (!hs && guard < 100);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    int c;
    c = 0;
    while (!done && !error && c < limit) begin
      step();
      c++;
    end
    check("end_reached", {31'b0, done | error}, 32'h1);
  endtask

  logic [31:0] img1 [$];
  logic [31:0] img4 [$];
  int          mark;
  int          acc0;
  int          cyc;
  logic        ready_after_last;

  initial begin
    img1 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    img4 = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    fault_en    = 1'b0;
    fault_addr  = 16'h0102;
    base_addr   = '0;
    word_count  = '0;
    bus.s_data  = '0;
    do_reset();

    // Reset state
    check("rst_ctrl", {25'b0, core_reset_n, busy, done, error, bus.s_ready, bus.a_wr_en, 1'b0},
          32'h0);
    check("rst_strobe", {28'b0, bus.a_wr_strobe}, 32'h0);
    check("rst_addr", {16'b0, bus.a_addr}, 32'h0);

    // 1: gapped 4-word load at 0x0100
    mark = wr_addr_log.size();
    pulse_start(16'h0100, 16'd4);
    check("t1_busy", {31'b0, busy}, 32'h1);
    check("t1_core_held", {31'b0, core_reset_n}, 32'h0);
    feed(img1, 1'b1);
    wait_end(100);
    check("t1_nwr", wr_addr_log.size() - mark, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", {16'b0, wr_addr_log[mark+i]}, 32'h0100 + i);
      check("t1_data", wr_data_log[mark+i], img1[i]);
    end
    check("t1_done", {29'b0, done, error, core_reset_n}, 32'b101);
    check("t1_mem", mem[16'h0103], 32'h44444444);
    check("t1_no_wr_without_valid", n_bad_wr, 32'd0);

    // 2: same load with read fault at 0x0102, then clean reload
    fault_en = 1'b1;
    pulse_start(16'h0100, 16'd4);
    feed(img1, 1'b1);
    wait_end(100);
    check("t2_error", {29'b0, done, error, core_reset_n}, 32'b010);
    fault_en = 1'b0;
    pulse_start(16'h0100, 16'd4);
    feed(img1, 1'b1);
    wait_end(100);
    check("t2_recover", {29'b0, done, error, core_reset_n}, 32'b101);

    // 3: zero-length load
    do_reset();
    check("t3_pre_done", {31'b0, done}, 32'h0);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEADBEEF;
    mark = wr_addr_log.size();
    acc0 = n_acc;
    pulse_start(16'h0040, 16'd0);
    step();
    check("t3_done", {30'b0, done, busy}, 32'b10);
    check("t3_no_wr", wr_addr_log.size() - mark, 32'd0);
    check("t3_no_acc", n_acc - acc0, 32'd0);
    bus.s_valid = 1'b0;

    // 4: address wrap at top of space
    mark = wr_addr_log.size();
    pulse_start(16'hFFFE, 16'd4);
    feed(img4, 1'b0);
    wait_end(100);
    check("t4_a0", {16'b0, wr_addr_log[mark+0]}, 32'hFFFE);
    check("t4_a1", {16'b0, wr_addr_log[mark+1]}, 32'hFFFF);
    check("t4_a2", {16'b0, wr_addr_log[mark+2]}, 32'h0000);
    check("t4_a3", {16'b0, wr_addr_log[mark+3]}, 32'h0001);
    check("t4_mem", mem[16'h0000], 32'hC2C2C2C2);
    check("t4_done", {29'b0, done, error, core_reset_n}, 32'b101);

    // 5: start ignored during WRITE, then reset after two writes
    mark = wr_addr_log.size();
    pulse_start(16'h0200, 16'd8);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hC0C0C0C0;
    step();
    bus.s_valid = 1'b0;
    base_addr   = 16'h0300;
    word_count  = 16'd0;
    start       = 1'b1;
    step();
    start = 1'b0;
    check("t5_start_ignored", {30'b0, busy, done}, 32'b10);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hC1C1C1C1;
    step();
    bus.s_valid = 1'b0;
    reset       = 1'b1;
    step();
    check("t5_rst_ctrl", {25'b0, core_reset_n, busy, done, error, bus.s_ready, bus.a_wr_en, 1'b0},
          32'h0);
    check("t5_rst_addr", {16'b0, bus.a_addr}, 32'h0);
    check("t5_nwr", wr_addr_log.size() - mark, 32'd2);
    check("t5_addr1", {16'b0, wr_addr_log[mark+1]}, 32'h0201);
    check("t5_partial", mem[16'h0201], 32'hC1C1C1C1);
    reset = 1'b0;
    step();

    // 6: 256 words back-to-back, exact latency
    mark = wr_addr_log.size();
    acc0 = n_acc;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hC0DE0000;
    pulse_start(16'h1000, 16'd256);
    cyc = 0;
    ready_after_last = 1'b1;
    while (!done && !error && cyc < 2000) begin
      bus.s_data = {16'hC0DE, cyc[15:0]};
      if (cyc == 256) ready_after_last = bus.s_ready;
      step();
      cyc++;
    end
    bus.s_valid = 1'b0;
    check("t6_latency", cyc, 32'd513);
    check("t6_done", {29'b0, done, error, core_reset_n}, 32'b101);
    check("t6_ready_low", {31'b0, ready_after_last}, 32'h0);
    check("t6_nacc", n_acc - acc0, 32'd256);
    check("t6_last_addr", {16'b0, wr_addr_log[mark+255]}, 32'h10FF);
    check("t6_last_data", wr_data_log[mark+255], 32'hC0DE00FF);
    check("strobes", n_bad_strobe, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
